// File: rtl/seq_shifter_pkg.sv
// Shared definitions for the sequential shifter: mode encodings and FSM state type.
package seq_shifter_pkg;

    typedef logic [1:0] mode_t;

    localparam mode_t MODE_SLL = 2'b00;
    localparam mode_t MODE_SRL = 2'b01;
    localparam mode_t MODE_SRA = 2'b10;
    localparam mode_t MODE_ROL = 2'b11;

    typedef logic [1:0] state_t;

    localparam state_t ST_IDLE  = 2'd0;
    localparam state_t ST_SHIFT = 2'd1;
    localparam state_t ST_DONE  = 2'd2;

endpackage

// File: rtl/seq_shifter_shift_step.sv
// One-bit shift/rotate step. Rotate support exists only when SEQ_SHIFTER_ROTATE_EN
// is defined; otherwise mode 11 falls through to a logical left shift.
module shift_step
    import seq_shifter_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic [1:0]       mode,
    input  logic [WIDTH-1:0] operand,
    output logic [WIDTH-1:0] operand_next
);

    always_comb begin
        operand_next = {operand[WIDTH-2:0], 1'b0};
        case (mode)
            MODE_SRL: operand_next = {1'b0, operand[WIDTH-1:1]};
            MODE_SRA: operand_next = {operand[WIDTH-1], operand[WIDTH-1:1]};
`ifdef SEQ_SHIFTER_ROTATE_EN
            MODE_ROL: operand_next = {operand[WIDTH-2:0], operand[WIDTH-1]};
`endif
            default:  operand_next = {operand[WIDTH-2:0], 1'b0};
        endcase
    end

endmodule

// File: rtl/seq_shifter.sv
// Multi-cycle shifter: one bit per clock, result published with a one-cycle done pulse.
// Optional rotate mode enabled by defining SEQ_SHIFTER_ROTATE_EN.
module seq_shifter
    import seq_shifter_pkg::*;
#(
    parameter  int WIDTH   = 16,
    localparam int SHAMT_W = $clog2(WIDTH)
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic [1:0]         mode,
    input  logic [SHAMT_W-1:0] shamt,
    input  logic [WIDTH-1:0]   a,
    output logic [WIDTH-1:0]   y,
    output logic               busy,
    output logic               done
);

    state_t             state;
    mode_t              mode_q;
    logic [SHAMT_W-1:0] cnt;
    logic [WIDTH-1:0]   work;
    logic [WIDTH-1:0]   work_next;
    logic [WIDTH-1:0]   y_q;

    shift_step #(.WIDTH(WIDTH)) u_step (
        .mode         (mode_q),
        .operand      (work),
        .operand_next (work_next)
    );

    // y is loaded on the edge entering DONE so it is already valid while done is high
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= ST_IDLE;
            mode_q <= MODE_SLL;
            cnt    <= '0;
            work   <= '0;
            y_q    <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        work   <= a;
                        cnt    <= shamt;
                        mode_q <= mode;
                        if (shamt == '0) begin
                            y_q   <= a;
                            state <= ST_DONE;
                        end else begin
                            state <= ST_SHIFT;
                        end
                    end
                end
                ST_SHIFT: begin
                    work <= work_next;
                    cnt  <= cnt - 1'b1;
                    if (cnt == SHAMT_W'(1)) begin
                        y_q   <= work_next;
                        state <= ST_DONE;
                    end
                end
                ST_DONE: state <= ST_IDLE;
                default: state <= ST_IDLE;
            endcase
        end
    end

    assign y    = y_q;
    assign busy = (state != ST_IDLE);
    assign done = (state == ST_DONE);

endmodule

// File: tb/tb_seq_shifter.sv
// Scoreboard bench for seq_shifter (WIDTH=16); mode 11 expectation follows SEQ_SHIFTER_ROTATE_EN.
module tb_seq_shifter;

    localparam int W = 16;

    typedef struct {
        logic [W-1:0] y;
        int           cyc;
    } exp_t;

    logic         clk;
    logic         rst_n;
    logic         start;
    logic [1:0]   mode;
    logic [3:0]   shamt;
    logic [W-1:0] a;
    logic [W-1:0] y;
    logic         busy;
    logic         done;

    int   cyc;
    int   errors;
    int   checks;
    int   done_cnt;
    logic [W-1:0] last_y;
    exp_t sb[$];

    seq_shifter #(.WIDTH(W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
        .mode  (mode),
        .shamt (shamt),
        .a     (a),
        .y     (y),
        .busy  (busy),
        .done  (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    function automatic logic [W-1:0] model(input logic [1:0] m, input int s, input logic [W-1:0] v);
        logic signed [W-1:0] sv;
        sv = v;
        case (m)
            2'b00: return v << s;
            2'b01: return v >> s;
            2'b10: return sv >>> s;
            default: begin
`ifdef SEQ_SHIFTER_ROTATE_EN
                if (s == 0) return v;
                return (v << s) | (v >> (W - s));
`else
                return v << s;
`endif
            end
        endcase
    endfunction

    // Monitor: pops one expectation per done pulse, and checks y stays put otherwise
    always @(negedge clk) begin
        if (!rst_n) begin
            last_y = '0;
        end else if (done) begin
            done_cnt++;
            if (sb.size() == 0) begin
                chk("unexpected_done", 32'(done), 32'(0));
            end else begin
                exp_t e;
                e = sb.pop_front();
                chk("y", 32'(y), 32'(e.y));
                chk("done_cycle", 32'(cyc), 32'(e.cyc));
            end
            last_y = y;
        end else begin
            chk("y_hold", 32'(y), 32'(last_y));
        end
    end

    task automatic start_op(input logic [1:0] m, input int s, input logic [W-1:0] av,
                            input bit expect_done, input bit release_rst);
        exp_t e;
        @(posedge clk);
        #1;
        if (release_rst) rst_n = 1'b1;
        start = 1'b1;
        mode  = m;
        shamt = 4'(s);
        a     = av;
        if (expect_done) begin
            e.y   = model(m, s, av);
            e.cyc = cyc + s + 1;
            sb.push_back(e);
        end
        @(posedge clk);
        #1;
        start = 1'b0;
        mode  = 2'($urandom);
        shamt = 4'($urandom);
        a     = W'($urandom);
    endtask

    task automatic wait_done();
        int prev;
        prev = done_cnt;
        for (int i = 0; i < W + 8 && done_cnt == prev; i++) begin
            @(negedge clk);
            #1;
        end
        chk("done_seen", 32'(done_cnt), 32'(prev + 1));
    endtask

    task automatic run(input logic [1:0] m, input int s, input logic [W-1:0] av);
        start_op(m, s, av, 1'b1, 1'b0);
        wait_done();
    endtask

    initial begin
        errors   = 0;
        checks   = 0;
        done_cnt = 0;
        last_y   = '0;
        rst_n    = 1'b0;
        start    = 1'b0;
        mode     = 2'b00;
        shamt    = 4'd0;
        a        = '0;

        repeat (3) @(posedge clk);
        #1;
        chk("reset_y", 32'(y), 32'(0));
        chk("reset_busy", 32'(busy), 32'(0));
        chk("reset_done", 32'(done), 32'(0));
        rst_n = 1'b1;

        run(2'b00, 2, 16'hffff);
        run(2'b10, 4, 16'habcd);
        run(2'b01, 4, 16'habcd);
        run(2'b11, 4, 16'habcd);
        run(2'b00, 0, 16'h1234);
        run(2'b00, 15, 16'h1234);
        run(2'b10, 15, 16'h8000);
        run(2'b11, 15, 16'h8001);

        // Second start issued three cycles in must be dropped
        begin
            start_op(2'b00, 8, 16'h0001, 1'b1, 1'b0);
            repeat (2) begin
                @(posedge clk);
                #1;
            end
            chk("busy_mid_op", 32'(busy), 32'(1));
            start = 1'b1;
            mode  = 2'b01;
            shamt = 4'd3;
            a     = 16'hffff;
            @(posedge clk);
            #1;
            start = 1'b0;
            wait_done();
            repeat (W + 4) @(posedge clk);
        end

        // Reset two cycles into a shamt=10 operation, then restart on the first edge
        begin
            run(2'b01, 3, 16'hf0f0);
            start_op(2'b00, 10, 16'h5a5a, 1'b0, 1'b0);
            @(posedge clk);
            #1;
            rst_n = 1'b0;
            #1;
            chk("rst_mid_y", 32'(y), 32'(0));
            chk("rst_mid_busy", 32'(busy), 32'(0));
            chk("rst_mid_done", 32'(done), 32'(0));
            repeat (2) @(posedge clk);
            start_op(2'b10, 5, 16'h8421, 1'b1, 1'b1);
            wait_done();
        end

        for (int n = 0; n < 40; n++) begin
            int gap;
            gap = int'($urandom_range(0, 2));
            repeat (gap) @(posedge clk);
            run(2'($urandom), int'($urandom_range(0, W - 1)), W'($urandom));
        end

        repeat (4) @(posedge clk);
        chk("sb_empty", 32'(sb.size()), 32'(0));
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
